// File: rtl/wish_pkg.sv
// Shared Wishbone definitions: FSM state encoding, default widths and a small
// helper used by the master and the responder FSM.
package wish_pkg;

  localparam int DEFAULT_ADDRESS_LENGTH = 32;
  localparam int DEFAULT_DATA_LENGTH    = 32;
  localparam int DEFAULT_TIMEOUT        = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } wish_state_t;

  // Bits needed to count 0 .. max_count-1, never less than one bit.
  function automatic int count_width(input int max_count);
    return (max_count < 3) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/wish_if.sv
// Wishbone initiator/responder bus bundle with master and slave views.
interface wish_if
  import wish_pkg::*;
#(
  parameter int ADDRESS_LENGTH = DEFAULT_ADDRESS_LENGTH,
  parameter int DATA_LENGTH    = DEFAULT_DATA_LENGTH
);

  logic [ADDRESS_LENGTH-1:0] ADR_O;
  logic [DATA_LENGTH-1:0]    DAT_O;
  logic                      WE_O;
  logic                      STB_O;
  logic                      CYC_O;
  logic [DATA_LENGTH-1:0]    DAT_I;
  logic                      ACK_I;

  modport master (
    output ADR_O, DAT_O, WE_O, STB_O, CYC_O,
    input  DAT_I, ACK_I
  );

  modport slave (
    input  ADR_O, DAT_O, WE_O, STB_O, CYC_O,
    output DAT_I, ACK_I
  );

endinterface

// File: rtl/wish_timeout.sv
// Counts cycles while enabled; expired is high during the TIMEOUT-th enabled
// cycle so the master can leave on that same edge.
module wish_timeout
  import wish_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = count_width(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Saturates at LAST so a stalled enable never wraps back to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = en && (count == LAST);

endmodule

// File: rtl/wish_master.sv
// Single-transfer Wishbone initiator: IDLE -> ACTIVE -> DONE.
// Define WISH_TIMEOUT_EN to abort a transfer after TIMEOUT cycles without ACK_I.
module wish_master
  import wish_pkg::*;
#(
  parameter int ADDRESS_LENGTH = DEFAULT_ADDRESS_LENGTH,
  parameter int DATA_LENGTH    = DEFAULT_DATA_LENGTH,
  parameter int TIMEOUT        = DEFAULT_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req,
  input  logic                      req_we,
  input  logic [ADDRESS_LENGTH-1:0] req_adr,
  input  logic [DATA_LENGTH-1:0]    req_dat,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [DATA_LENGTH-1:0]    rdata,
  wish_if.master                    bus
);

  wish_state_t state;
  wish_state_t next_state;
  logic        start;
  logic        capture;

`ifdef WISH_TIMEOUT_EN
  logic expired;
  logic timeout_hit;
  logic err_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ACK_I is only looked at in ACTIVE, and it wins over a simultaneous timeout.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    capture    = 1'b0;
`ifdef WISH_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (req) begin
          next_state = ACTIVE;
          start      = 1'b1;
        end
      end
      ACTIVE: begin
        if (bus.ACK_I) begin
          next_state = DONE;
          capture    = ~bus.WE_O;
        end
`ifdef WISH_TIMEOUT_EN
        else if (expired) begin
          next_state  = DONE;
          timeout_hit = 1'b1;
        end
`endif
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ADR_O <= '0;
      bus.DAT_O <= '0;
      bus.WE_O  <= 1'b0;
      rdata     <= '0;
    end else begin
      if (start) begin
        bus.ADR_O <= req_adr;
        bus.DAT_O <= req_dat;
        bus.WE_O  <= req_we;
      end
      if (capture) begin
        rdata <= bus.DAT_I;
      end
    end
  end

  // Strobes decode straight from the state register, so reset drops them at once.
  assign bus.CYC_O = (state == ACTIVE);
  assign bus.STB_O = (state == ACTIVE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

`ifdef WISH_TIMEOUT_EN
  wish_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (state != ACTIVE),
    .en      (state == ACTIVE),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout_hit;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_wish_master.sv
// Directed self-checking bench for wish_master; the timeout section follows
// WISH_TIMEOUT_EN so the same file covers both builds.
module tb_wish_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req;
  logic          req_we;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_dat;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] rdata;

  int checkCount = 0;
  int failCount  = 0;

  wish_if #(.ADDRESS_LENGTH(AW), .DATA_LENGTH(DW)) bus ();

  wish_master #(
    .ADDRESS_LENGTH (AW),
    .DATA_LENGTH    (DW),
    .TIMEOUT        (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .req_we  (req_we),
    .req_adr (req_adr),
    .req_dat (req_dat),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .rdata   (rdata),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    req     = r;
    req_we  = we;
    req_adr = adr;
    req_dat = dat;
  endtask

  task automatic setAck(input logic ack, input logic [DW-1:0] dat);
    bus.ACK_I = ack;
    bus.DAT_I = dat;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected bus/handshake view for one cycle: active means ACTIVE, fin means DONE.
  task automatic checkState(input string tag, input logic active, input logic fin);
    checkOutput({tag, ".cyc"},  bus.CYC_O, active);
    checkOutput({tag, ".stb"},  bus.STB_O, active);
    checkOutput({tag, ".busy"}, busy, active | fin);
    checkOutput({tag, ".done"}, done, fin);
  endtask

  initial begin
    int doneCount;
    int stbCount;

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0);
    setAck(1'b0, '0);
    step();
    step();

    // Reset values
    checkState("rst", 1'b0, 1'b0);
    checkOutput("rst.err",   err, 1'b0);
    checkOutput("rst.we",    bus.WE_O, 1'b0);
    checkOutput("rst.adr",   bus.ADR_O, 32'h0);
    checkOutput("rst.dat",   bus.DAT_O, 32'h0);
    checkOutput("rst.rdata", rdata, 32'h0);
    reset = 1'b0;
    step();

    // Read with ACK one cycle after STB
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    step();
    checkState("rd.act", 1'b1, 1'b0);
    checkOutput("rd.adr", bus.ADR_O, 32'h40);
    checkOutput("rd.we",  bus.WE_O, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    setAck(1'b1, 32'hDEAD_BEEF);
    step();
    checkState("rd.done", 1'b0, 1'b1);
    checkOutput("rd.err",   err, 1'b0);
    checkOutput("rd.rdata", rdata, 32'hDEAD_BEEF);
    setAck(1'b0, '0);
    step();
    checkState("rd.idle", 1'b0, 1'b0);

    // Write with ACK in the third ACTIVE cycle; request inputs change meanwhile
    applyStimulus(1'b1, 1'b1, 32'h0000_0080, 32'h1234_5678);
    step();
    applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hAAAA_AAAA);
    for (int i = 0; i < 3; i++) begin
      checkState($sformatf("wr.act%0d", i), 1'b1, 1'b0);
      checkOutput($sformatf("wr.adr%0d", i), bus.ADR_O, 32'h80);
      checkOutput($sformatf("wr.dat%0d", i), bus.DAT_O, 32'h1234_5678);
      checkOutput($sformatf("wr.we%0d", i),  bus.WE_O, 1'b1);
      if (i == 2) setAck(1'b1, 32'hBAD0_BAD0);
      step();
    end
    checkState("wr.done", 1'b0, 1'b1);
    checkOutput("wr.rdata", rdata, 32'hDEAD_BEEF);
    setAck(1'b0, '0);
    step();
    checkState("wr.idle", 1'b0, 1'b0);

    // req and ACK_I held high: one transfer per IDLE entry, period 3
    applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    setAck(1'b1, 32'h0000_0055);
    doneCount = 0;
    stbCount  = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      checkState($sformatf("b2b%0d", i), (i % 3) == 0, (i % 3) == 1);
      if (done) doneCount++;
      if (bus.STB_O) stbCount++;
    end
    applyStimulus(1'b0, 1'b0, '0, '0);
    setAck(1'b0, '0);
    checkOutput("b2b.dones", doneCount, 3);
    checkOutput("b2b.stbs",  stbCount, 3);
    checkOutput("b2b.rdata", rdata, 32'h55);

    // Reset in the second ACTIVE cycle
    applyStimulus(1'b1, 1'b0, 32'h0000_0200, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, '0, '0);
    step();
    checkState("rs.act2", 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkState("rs.async", 1'b0, 1'b0);
    checkOutput("rs.adr",   bus.ADR_O, 32'h0);
    checkOutput("rs.rdata", rdata, 32'h0);
    #1;
    reset = 1'b0;
    step();
    checkState("rs.after", 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0300, 32'h0);
    step();
    checkState("rs.act", 1'b1, 1'b0);
    checkOutput("rs.adr2", bus.ADR_O, 32'h300);
    applyStimulus(1'b0, 1'b0, '0, '0);
    setAck(1'b1, 32'hCAFE_F00D);
    step();
    checkState("rs.done", 1'b0, 1'b1);
    checkOutput("rs.rdata2", rdata, 32'hCAFE_F00D);
    setAck(1'b0, '0);
    step();

    // Spurious ACK while IDLE
    setAck(1'b1, 32'h1111_1111);
    for (int i = 0; i < 2; i++) begin
      step();
      checkState($sformatf("sp%0d", i), 1'b0, 1'b0);
      checkOutput($sformatf("sp.rdata%0d", i), rdata, 32'hCAFE_F00D);
    end
    setAck(1'b0, '0);

`ifdef WISH_TIMEOUT_EN
    // No ACK: abort after 4 ACTIVE cycles with err
    applyStimulus(1'b1, 1'b0, 32'h0000_0400, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkState($sformatf("to.act%0d", i + 2), 1'b1, 1'b0);
    end
    step();
    checkState("to.done", 1'b0, 1'b1);
    checkOutput("to.err",   err, 1'b1);
    checkOutput("to.rdata", rdata, 32'hCAFE_F00D);
    step();
    checkState("to.idle", 1'b0, 1'b0);
    checkOutput("to.err0", err, 1'b0);

    // ACK in the fourth ACTIVE cycle beats the timeout
    applyStimulus(1'b1, 1'b0, 32'h0000_0500, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, '0, '0);
    step();
    step();
    step();
    checkState("ta.act4", 1'b1, 1'b0);
    setAck(1'b1, 32'h0000_0077);
    step();
    checkState("ta.done", 1'b0, 1'b1);
    checkOutput("ta.err",   err, 1'b0);
    checkOutput("ta.rdata", rdata, 32'h77);
    setAck(1'b0, '0);
    step();
`else
    // No timeout build: ACTIVE waits well beyond TIMEOUT cycles for ACK_I
    applyStimulus(1'b1, 1'b0, 32'h0000_0400, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, '0, '0);
    repeat (20) step();
    checkState("wait.act", 1'b1, 1'b0);
    checkOutput("wait.err", err, 1'b0);
    setAck(1'b1, 32'h0000_0099);
    step();
    checkState("wait.done", 1'b0, 1'b1);
    checkOutput("wait.err2",  err, 1'b0);
    checkOutput("wait.rdata", rdata, 32'h99);
    setAck(1'b0, '0);
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
